// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares a single 16-bit Hack-style ALU between NREQ requesters (2..4).
// Each cycle a round-robin search picks one valid requester, its control
// word and operands are pushed through the combinational ALU, and the
// result is captured in a single-entry response register together with
// the zero/negative flags and the index of the winning requester.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous, active-high reset
//   req_valid  : [NREQ]    request valid, one bit per requester
//   req_ready  : [NREQ]    request accepted, one-hot or zero
//   req_c      : [6*NREQ]  control words, slice i = [6i+5:6i]
//                          bit 5 zx, 4 nx, 3 zy, 2 ny, 1 f, 0 no
//   req_x      : [16*NREQ] x operands, slice i = [16i+15:16i]
//   req_y      : [16*NREQ] y operands, same slicing as req_x
//   rsp_valid  : response register holds a result
//   rsp_ready  : consumer accepts the response
//   rsp_out    : registered ALU result
//   rsp_zr     : registered (result == 0)
//   rsp_ng     : registered result bit 15
//   rsp_id     : index of the requester that produced the response
//   busy       : mirror of rsp_valid
//
// Configuration macro
//   ALU_ARB_FLAGS_EN : when defined, rsp_zr/rsp_ng are registered with the
//                      result; when undefined, no flag registers exist and
//                      both flag outputs are tied to 0.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// ALU
//
// Purely combinational Hack ALU datapath.
//   c   : 6-bit control word {zx, nx, zy, ny, f, no}
//   x,y : 16-bit operands
//   out : 16-bit result
// The flags are derived by the arbiter from its registered copy of the
// result path, so only the data result is exported here.
// ---------------------------------------------------------------------------
module ALU (
  input  logic [5:0]  c,
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [15:0] out
);

  logic [15:0] x_z;
  logic [15:0] x_n;
  logic [15:0] y_z;
  logic [15:0] y_n;
  logic [15:0] f_res;

  // Operand preconditioning, function select and output negation applied
  // strictly in the order zx, nx, zy, ny, f, no.
  always_comb begin
    x_z   = c[5] ? 16'h0000 : x;
    x_n   = c[4] ? ~x_z : x_z;
    y_z   = c[3] ? 16'h0000 : y;
    y_n   = c[2] ? ~y_z : y_z;
    f_res = c[1] ? (x_n + y_n) : (x_n & y_n);
    out   = c[0] ? ~f_res : f_res;
  end

endmodule

// ---------------------------------------------------------------------------
// alu_arbiter (top)
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int NREQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [6*NREQ-1:0]  req_c,
  input  logic [16*NREQ-1:0] req_x,
  input  logic [16*NREQ-1:0] req_y,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [15:0]        rsp_out,
  output logic               rsp_zr,
  output logic               rsp_ng,
  output logic [1:0]         rsp_id,
  output logic               busy
);

  // Response register and round-robin pointer state.
  logic        valid_q, valid_d;
  logic [15:0] out_q,   out_d;
  logic [1:0]  id_q,    id_d;
  logic [1:0]  ptr_q,   ptr_d;

  // Arbitration results.
  logic        slot_free;
  logic        grant_found;
  logic [1:0]  grant_idx;
  logic        transfer;

  // Payload of the granted requester and the ALU result for it.
  logic [5:0]  sel_c;
  logic [15:0] sel_x;
  logic [15:0] sel_y;
  logic [15:0] alu_out;

  // The response slot can take a new result if it is empty or is being
  // drained this same cycle, which is what gives back-to-back throughput.
  assign slot_free = !valid_q || rsp_ready;

  // Round-robin search: walk the requesters starting at ptr_q and wrap
  // around, stopping at the first valid one. The inner loop only serves to
  // turn the rotated index into a constant bit select.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_found && (i == (int'(ptr_q) + k) % NREQ) && req_valid[i]) begin
          grant_found = 1'b1;
          grant_idx   = 2'(i);
        end
      end
    end
  end

  // The grant is only presented when the slot can accept it and never
  // while reset is asserted, so a request seen in a reset cycle is held
  // off until the first cycle after reset.
  always_comb begin
    req_ready = '0;
    if (!rst && slot_free && grant_found) begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant_idx == 2'(i)) begin
          req_ready[i] = 1'b1;
        end
      end
    end
  end

  // req_ready is only ever raised on a valid requester, so any set bit is
  // a completed handshake.
  assign transfer = |(req_valid & req_ready);

  // Route the winner's control word and operands to the shared ALU.
  always_comb begin
    sel_c = '0;
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == 2'(i)) begin
        sel_c = req_c[6*i +: 6];
        sel_x = req_x[16*i +: 16];
        sel_y = req_y[16*i +: 16];
      end
    end
  end

  ALU u_alu (
    .c   (sel_c),
    .x   (sel_x),
    .y   (sel_y),
    .out (alu_out)
  );

  // Next-state for the response register and pointer. A grant always wins
  // over a plain drain: if both happen together the register is simply
  // overwritten and stays valid. The pointer only moves on a grant so that
  // idle cycles leave the rotation where it was.
  always_comb begin
    valid_d = valid_q;
    out_d   = out_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (transfer) begin
      valid_d = 1'b1;
      out_d   = alu_out;
      id_d    = grant_idx;
      ptr_d   = (int'(grant_idx) == NREQ - 1) ? 2'd0 : grant_idx + 2'd1;
    end else if (valid_q && rsp_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      out_q   <= 16'h0000;
      id_q    <= 2'd0;
      ptr_q   <= 2'd0;
    end else begin
      valid_q <= valid_d;
      out_q   <= out_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ALU_ARB_FLAGS_EN
  // Flags are computed from the ALU result going into the register and
  // captured in the same edge, so they never lag or glitch relative to
  // rsp_out.
  logic zr_q, zr_d;
  logic ng_q, ng_d;

  always_comb begin
    zr_d = zr_q;
    ng_d = ng_q;
    if (transfer) begin
      zr_d = (alu_out == 16'h0000);
      ng_d = alu_out[15];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zr_q <= 1'b0;
      ng_q <= 1'b0;
    end else begin
      zr_q <= zr_d;
      ng_q <= ng_d;
    end
  end

  assign rsp_zr = zr_q;
  assign rsp_ng = ng_q;
`else
  assign rsp_zr = 1'b0;
  assign rsp_ng = 1'b0;
`endif

  assign rsp_valid = valid_q;
  assign rsp_out   = out_q;
  assign rsp_id    = id_q;
  assign busy      = valid_q;

endmodule
